// File: rtl/jesd204b_rx_lane_sync.sv
// Per-lane JESD204B RX link layer: code group sync, ILAS check, user data forwarding.
// Define JESD_ILAS_CAPTURE_EN to capture the 14 ILAS configuration octets of multiframe 1.
module jesd204b_rx_lane_sync #(
  parameter int unsigned K_COUNT       = 4,
  parameter int unsigned OCTETS_PER_MF = 32,
  parameter int unsigned ILAS_MF       = 4,
  parameter int unsigned ERR_THRESH    = 8
) (
  input  logic          rxusrclk2_in,
  input  logic          rx_reset_in,
  input  logic [31:0]   rxdata_in,
  input  logic [3:0]    rxcharisk_in,
  input  logic [3:0]    rxdisperr_in,
  input  logic [3:0]    rxnotintable_in,
  input  logic          rxbyteisaligned_in,
  output logic          sync_n_out,
  output logic          rxmcommaalignen_out,
  output logic          rxpcommaalignen_out,
  output logic          cgs_done_out,
  output logic          ilas_done_out,
  output logic [31:0]   data_out,
  output logic          data_valid_out,
  output logic [7:0]    err_cnt_out,
  output logic [111:0]  ilas_cfg_out
);

  localparam int unsigned WPM     = OCTETS_PER_MF / 4;
  localparam int unsigned W_W     = (WPM > 1) ? $clog2(WPM) : 1;
  localparam int unsigned M_W     = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int unsigned KC_W    = 4;
  localparam int unsigned ERR_W   = 8;
  localparam logic [7:0]  K28_5   = 8'hBC;
  localparam logic [7:0]  K28_0   = 8'h1C;
  localparam logic [7:0]  K28_4   = 8'h9C;
  localparam logic [7:0]  K28_3   = 8'h7C;

  typedef enum logic [1:0] {CGS_INIT, CGS_WAIT, ILAS, DATA} state_t;

  state_t            state_q, state_d;
  logic [KC_W-1:0]   kc_q, kc_d, kc_scan, kc_lim;
  logic              kc_hit;
  logic [W_W-1:0]    w_q, w_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ilas_ok;
  logic [3:0]        is_k285, oct_err;
  logic              word_err, all_k285, r0, q1, a3;

  // Octet classification of the current lane word
  always_comb begin
    is_k285 = '0;
    for (int i = 0; i < 4; i++) begin
      is_k285[i] = rxcharisk_in[i] && (rxdata_in[8*i +: 8] == K28_5);
    end
    oct_err  = rxdisperr_in | rxnotintable_in;
    word_err = |oct_err;
    all_k285 = &is_k285;
    r0       = rxcharisk_in[0] && (rxdata_in[7:0]   == K28_0);
    q1       = rxcharisk_in[1] && (rxdata_in[15:8]  == K28_4);
    a3       = rxcharisk_in[3] && (rxdata_in[31:24] == K28_3);
  end

  // Next-state logic; kc counts consecutive clean K28.5 octets across word boundaries
  always_comb begin
    state_d = state_q;
    kc_d    = '0;
    w_d     = w_q;
    m_d     = m_q;
    err_d   = err_q;
    kc_scan = kc_q;
    kc_hit  = 1'b0;
    ilas_ok = 1'b1;
    kc_lim  = (state_q == DATA) ? KC_W'(4) : KC_W'(K_COUNT);

    for (int i = 0; i < 4; i++) begin
      if (is_k285[i] && !oct_err[i] && (rxbyteisaligned_in || state_q != CGS_INIT)) begin
        if (kc_scan < kc_lim) kc_scan = kc_scan + KC_W'(1);
        if (kc_scan == kc_lim) kc_hit = 1'b1;
      end else begin
        kc_scan = '0;
      end
    end

    case (state_q)
      CGS_INIT: begin
        if (kc_hit) state_d = CGS_WAIT;
        else        kc_d    = kc_scan;
      end
      CGS_WAIT: begin
        if (!word_err && all_k285) begin
          state_d = CGS_WAIT;
        end else if (!word_err && r0) begin
          state_d = ILAS;
          w_d     = W_W'(1);
          m_d     = '0;
        end else begin
          state_d = CGS_INIT;
        end
      end
      ILAS: begin
        if (word_err)                                        ilas_ok = 1'b0;
        if (w_q == '0 && !r0)                                ilas_ok = 1'b0;
        if (w_q == '0 && m_q == M_W'(1) && !q1)              ilas_ok = 1'b0;
        if (w_q == W_W'(WPM - 1) && !a3)                     ilas_ok = 1'b0;
        if (!ilas_ok) begin
          state_d = CGS_INIT;
        end else if (w_q == W_W'(WPM - 1)) begin
          w_d = '0;
          if (m_q == M_W'(ILAS_MF - 1)) begin
            state_d = DATA;
            err_d   = '0;
          end else begin
            m_d = m_q + M_W'(1);
          end
        end else begin
          w_d = w_q + W_W'(1);
        end
      end
      DATA: begin
        if (word_err && err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        if ((word_err && err_d >= ERR_W'(ERR_THRESH)) || kc_hit) state_d = CGS_INIT;
        else                                                     kc_d    = kc_scan;
      end
      default: state_d = CGS_INIT;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge rxusrclk2_in) begin
    if (rx_reset_in) begin
      state_q             <= CGS_INIT;
      kc_q                <= '0;
      w_q                 <= '0;
      m_q                 <= '0;
      err_q               <= '0;
      sync_n_out          <= 1'b0;
      rxmcommaalignen_out <= 1'b1;
      cgs_done_out        <= 1'b0;
      ilas_done_out       <= 1'b0;
      data_valid_out      <= 1'b0;
      data_out            <= '0;
    end else begin
      state_q             <= state_d;
      kc_q                <= kc_d;
      w_q                 <= w_d;
      m_q                 <= m_d;
      err_q               <= err_d;
      sync_n_out          <= (state_d != CGS_INIT);
      rxmcommaalignen_out <= (state_d == CGS_INIT);
      cgs_done_out        <= (state_d != CGS_INIT);
      ilas_done_out       <= (state_d == DATA);
      data_valid_out      <= (state_q == DATA) && (state_d == DATA);
      if (state_q == DATA && state_d == DATA) data_out <= rxdata_in;
    end
  end

  assign err_cnt_out         = err_q;
  assign rxpcommaalignen_out = rxmcommaalignen_out;

`ifdef JESD_ILAS_CAPTURE_EN
  logic [111:0] cfg_q, cfg_d;

  // Config octets follow /R/ /Q/ in multiframe 1: word 0 upper half, then words 1..3
  always_comb begin
    cfg_d = cfg_q;
    if (state_q == CGS_WAIT && state_d == ILAS) begin
      cfg_d = '0;
    end else if (state_q == ILAS && m_q == M_W'(1)) begin
      case (int'(w_q))
        0:       cfg_d[15:0]   = rxdata_in[31:16];
        1:       cfg_d[47:16]  = rxdata_in;
        2:       cfg_d[79:48]  = rxdata_in;
        3:       cfg_d[111:80] = rxdata_in;
        default: cfg_d         = cfg_q;
      endcase
    end
  end

  always_ff @(posedge rxusrclk2_in) begin
    if (rx_reset_in) cfg_q <= '0;
    else             cfg_q <= cfg_d;
  end

  assign ilas_cfg_out = cfg_q;
`else
  assign ilas_cfg_out = '0;
`endif

endmodule
